timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL provide parameter N_REQ, default 4, number of requesters sharing one timer.
REQ-002 SHALL provide parameter WIDTH, default 32, timer load/value width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester timeout request; level, held until done or withdrawn.
REQ-006 req_load  input  N_REQ*WIDTH  flattened load values; slice i = req_load[i*WIDTH +: WIDTH].
REQ-007 grant  output  N_REQ  one-hot owner of the timer; all zeros when idle.
REQ-008 done  output  N_REQ  one-cycle pulse to the owner on timeout.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 timer_enable  output  1  drives the shared timer's enable.
REQ-011 timer_load  output  WIDTH  drives the shared timer's load value; registered.
REQ-012 timer_timeout  input  1  the shared timer's timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-014 IDLE: timer_enable=0; if any req bit is high, SHALL select the winner round-robin, searching from last_grant+1 upward with wrap-around.
REQ-015 On selection, SHALL latch the winner index and its req_load slice into timer_load, then go to LOAD.
REQ-016 LOAD: timer_enable=0 for exactly one cycle so the timer captures timer_load; then go to RUN.
REQ-017 RUN: timer_enable=1; timer_timeout sampled high SHALL move to DONE.
REQ-018 RUN: owner's req sampled low SHALL abort; go to IDLE with no done pulse; last_grant updated to owner.
REQ-019 Abort and timeout sampled in the same cycle: abort SHALL win, with no done pulse.
REQ-020 DONE: done[owner]=1 for exactly one cycle and timer_enable=0; last_grant set to owner; then go to IDLE.
REQ-021 grant[owner] SHALL be high from LOAD through DONE inclusive, and zero in IDLE.
REQ-022 timer_load SHALL hold constant from LOAD until the next selection.
REQ-023 Changes to req_load of the owner after selection SHALL be ignored.
REQ-024 Requests from non-owners SHALL wait; no preemption.
REQ-025 Owner still requesting in IDLE after DONE SHALL get the lowest priority in the next arbitration.
REQ-026 Load value 0 SHALL be legal; the timer times out with minimum latency.
REQ-027 Latency with the team's timer (timeout registered one cycle after count reaches 0): done SHALL pulse L+4 cycles after the edge that sampled req in IDLE, where L is the load value.
REQ-028 A single pending request SHALL be granted after one IDLE cycle; back-to-back service SHALL insert exactly one IDLE cycle between DONE and the next LOAD.

Reset
REQ-029 Asserting rst at any time, including mid-RUN, SHALL immediately force state IDLE, grant=0, done=0, busy=0, timer_enable=0, and timer_load=0.
REQ-030 On reset, last_grant SHALL be N_REQ-1, so requester 0 has first priority.
REQ-031 After reset deassertion, the first arbitration SHALL occur on the first posedge with req nonzero.

Verification
REQ-032 Single request: req=4'b0001, load0=3 -> grant=0001 the cycle after sampling; timer_enable high 5 cycles; done[0] pulses at sample+7; busy low the next cycle.
REQ-033 Round-robin: req=4'b1111 held, all loads=1 -> grants in order 0,1,2,3,0; each done followed by one IDLE cycle.
REQ-034 Abort: req0 load=10, drop req0 on the 3rd RUN cycle -> no done[0]; timer_enable low the next cycle; grant=0; pending req1 granted after one IDLE cycle.
REQ-035 Simultaneous abort and timeout: load=0, drop req in the cycle timer_timeout is sampled high -> no done pulse; FSM returns to IDLE.
REQ-036 Reset mid-RUN: assert rst asynchronously mid-cycle -> all outputs 0 before the next edge; after release with req=4'b0100, requester 2 is granted.
REQ-037 Load latch: change req_load slice 1 during RUN -> timer_load unchanged; done timing matches the original value.

Source files
------------

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one external timer among N_REQ requesters.
// Each grant loads the timer, runs it to timeout (or until the owner withdraws) and pulses done.
module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_load,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   timer_enable,
    output logic [WIDTH-1:0]       timer_load,
    input  logic                   timer_timeout
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, last_q, last_d, pick, cand;
    logic [WIDTH-1:0] load_q, load_d;
    logic found;
    // First requester after last_q, wrapping, wins
    always_comb begin
        pick = last_q;
        cand = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(last_q) + i) % N_REQ);
            if (!found && req[cand]) begin
                pick = cand;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        load_d = load_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = LOAD;
                owner_d = pick;
                load_d = req_load[int'(pick)*WIDTH +: WIDTH];
            end
            LOAD: state_d = RUN;
            // Withdrawal beats a coincident timeout
            RUN: if (!req[owner_q]) begin
                state_d = IDLE;
                last_d = owner_q;
            end else if (timer_timeout) begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                last_d = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q <= IW'(N_REQ - 1);
            load_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q <= last_d;
            load_q <= load_d;
        end
    end
    assign busy = state_q != IDLE;
    assign timer_enable = state_q == RUN;
    assign timer_load = load_q;
    assign grant = busy ? N_REQ'(1) << owner_q : '0;
    assign done = state_q == DONE ? grant : '0;
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: scoreboard bench for timer_arbiter driving a model of the team's timer.
// Expected done pulses (owner, cycle) are queued when requests are driven and popped on done.
module tb_timer_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] req_load = '0;
    logic [N-1:0] grant, done;
    logic busy, timer_enable, timer_timeout;
    logic [W-1:0] timer_load;
    logic [W-1:0] cnt;
    logic tto;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {int idx; int cyc;} exp_t;
    exp_t sb[$];

    timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_load(req_load),
        .grant(grant), .done(done), .busy(busy), .timer_enable(timer_enable),
        .timer_load(timer_load), .timer_timeout(timer_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Team timer: captures load while disabled, counts down while enabled,
    // timeout registered one cycle after the count sits at zero.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            tto <= 1'b0;
        end else begin
            if (!timer_enable) cnt <= timer_load;
            else if (cnt != '0) cnt <= cnt - 1;
            tto <= timer_enable && cnt == '0;
        end
    end
    assign timer_timeout = tto;

    task automatic set_load(input int i, input logic [W-1:0] v);
        req_load[i*W +: W] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int max, output logic [N-1:0] d, output int c, output int en);
        d = '0;
        c = -1;
        en = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (timer_enable) en++;
            if (done != '0) begin
                d = done;
                c = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({grant, done, busy, timer_enable, timer_load} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got grant=%b done=%b busy=%b en=%b load=%0d, want all 0",
                     grant, done, busy, timer_enable, timer_load);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int loads[2] = '{3, 0};
        int e0, c, en;
        logic [N-1:0] d;
        exp_t e;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_load(0, W'(loads[k]));
            req = 4'b0001;
            e0 = cyc + 1;
            sb.push_back('{0, e0 + loads[k] + 3});
            @(negedge clk);
            n_cmp++;
            if (grant !== 4'b0001 || timer_load !== W'(loads[k])) begin
                n_bad++;
                $display("FAIL single_grant: got grant=%b load=%0d, want 0001 load=%0d", grant, timer_load, loads[k]);
            end
            wait_done(40, d, c, en);
            e = sb.pop_front();
            n_cmp++;
            if (d !== N'(1 << e.idx) || c != e.cyc) begin
                n_bad++;
                $display("FAIL single_done: got done=%b at %0d, want %b at %0d", d, c, N'(1 << e.idx), e.cyc);
            end
            n_cmp++;
            if (en != loads[k] + 2) begin
                n_bad++;
                $display("FAIL single_enable_cycles: got %0d, want %0d", en, loads[k] + 2);
            end
            req = '0;
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("FAIL single_idle: got busy=%b, want 0", busy);
            end
        end
    endtask

    task automatic test_round_robin();
        int e0, c, en;
        logic [N-1:0] d;
        exp_t e;
        do_reset();
        for (int i = 0; i < N; i++) set_load(i, 1);
        req = 4'b1111;
        e0 = cyc + 1;
        for (int k = 0; k < 5; k++) sb.push_back('{k % N, e0 + 4 + 6 * k});
        for (int k = 0; k < 5; k++) begin
            wait_done(20, d, c, en);
            e = sb.pop_front();
            n_cmp++;
            if (d !== N'(1 << e.idx) || c != e.cyc) begin
                n_bad++;
                $display("FAIL rr_done_%0d: got done=%b at %0d, want %b at %0d", k, d, c, N'(1 << e.idx), e.cyc);
            end
            if (k == 4) req = '0;
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || grant !== '0) begin
                n_bad++;
                $display("FAIL rr_idle_gap_%0d: got busy=%b grant=%b, want 0/0000", k, busy, grant);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_quiet: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_abort();
        int e0, c, en;
        logic [N-1:0] d;
        exp_t e;
        do_reset();
        set_load(0, 10);
        set_load(1, 2);
        req = 4'b0011;
        e0 = cyc + 1;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL abort_first_grant: got %b, want 0001", grant);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (timer_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_running: got en=%b, want 1", timer_enable);
        end
        req = 4'b0010;
        sb.push_back('{1, e0 + 10});
        @(negedge clk);
        n_cmp++;
        if ({grant, done, busy, timer_enable} !== '0) begin
            n_bad++;
            $display("FAIL abort_idle: got grant=%b done=%b busy=%b en=%b, want all 0", grant, done, busy, timer_enable);
        end
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0010 || timer_load !== 32'd2) begin
            n_bad++;
            $display("FAIL abort_next_grant: got grant=%b load=%0d, want 0010 load=2", grant, timer_load);
        end
        wait_done(20, d, c, en);
        e = sb.pop_front();
        n_cmp++;
        if (d !== N'(1 << e.idx) || c != e.cyc) begin
            n_bad++;
            $display("FAIL abort_next_done: got done=%b at %0d, want %b at %0d", d, c, N'(1 << e.idx), e.cyc);
        end
        req = '0;
    endtask

    task automatic test_abort_timeout();
        int c, en;
        logic [N-1:0] d;
        do_reset();
        set_load(0, 0);
        req = 4'b0001;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({timer_timeout, timer_enable} !== 2'b11) begin
            n_bad++;
            $display("FAIL abto_setup: got tto=%b en=%b, want 1/1", timer_timeout, timer_enable);
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== '0) begin
            n_bad++;
            $display("FAIL abto_idle: got busy=%b done=%b, want 0/0000", busy, done);
        end
        wait_done(6, d, c, en);
        n_cmp++;
        if (d !== '0) begin
            n_bad++;
            $display("FAIL abto_no_done: got done=%b at %0d, want none", d, c);
        end
    endtask

    task automatic test_reset_mid_run();
        int e0, c, en;
        logic [N-1:0] d;
        exp_t e;
        do_reset();
        set_load(0, 20);
        req = 4'b0001;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (timer_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL rstrun_running: got en=%b, want 1", timer_enable);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({grant, done, busy, timer_enable, timer_load} !== '0) begin
            n_bad++;
            $display("FAIL rstrun_async: got grant=%b done=%b busy=%b en=%b load=%0d, want all 0",
                     grant, done, busy, timer_enable, timer_load);
        end
        @(negedge clk);
        set_load(2, 2);
        req = 4'b0100;
        rst = 1'b0;
        e0 = cyc + 1;
        sb.push_back('{2, e0 + 5});
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0100 || timer_load !== 32'd2) begin
            n_bad++;
            $display("FAIL rstrun_grant: got grant=%b load=%0d, want 0100 load=2", grant, timer_load);
        end
        wait_done(20, d, c, en);
        e = sb.pop_front();
        n_cmp++;
        if (d !== N'(1 << e.idx) || c != e.cyc) begin
            n_bad++;
            $display("FAIL rstrun_done: got done=%b at %0d, want %b at %0d", d, c, N'(1 << e.idx), e.cyc);
        end
        req = '0;
    endtask

    task automatic test_load_latch();
        int e0, c, en;
        logic [N-1:0] d;
        exp_t e;
        do_reset();
        set_load(1, 4);
        req = 4'b0010;
        e0 = cyc + 1;
        sb.push_back('{1, e0 + 7});
        repeat (3) @(negedge clk);
        set_load(1, 99);
        @(negedge clk);
        n_cmp++;
        if (timer_load !== 32'd4) begin
            n_bad++;
            $display("FAIL latch_run_load: got %0d, want 4", timer_load);
        end
        wait_done(20, d, c, en);
        e = sb.pop_front();
        n_cmp++;
        if (d !== N'(1 << e.idx) || c != e.cyc) begin
            n_bad++;
            $display("FAIL latch_done: got done=%b at %0d, want %b at %0d", d, c, N'(1 << e.idx), e.cyc);
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (timer_load !== 32'd4) begin
            n_bad++;
            $display("FAIL latch_hold: got %0d, want 4", timer_load);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_abort_timeout();
        test_reset_mid_run();
        test_load_latch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end
endmodule
